ram_burst_reader: RTL and testbench

Streaming read controller for the 64 x 8 single-port RAM, which is written on the clock edge and read combinationally. On a start command it reads a run of consecutive RAM locations and presents each byte on a valid/ready output stream, honouring backpressure. It sits between the RAM's port and any downstream consumer, such as a serializer or checksum unit. It never writes the RAM.

---
 rtl/ram_burst_reader_if.sv | 29 ++
 rtl/ram_burst_reader.sv | 90 +++++++++
 tb/tb_ram_burst_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_reader_if.sv
// Command, RAM-port and output-stream signals of the burst reader.
// The reader attaches to the master modport and its environment to the slave modport.
interface ram_burst_reader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    input  start, start_addr, len, ram_dout, m_ready,
    output busy, done, ram_we, ram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, start_addr, len, ram_dout, m_ready,
    input  busy, done, ram_we, ram_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Reads a run of consecutive locations from a combinational-read RAM and streams
// them out over valid/ready. The output register acts as a one-entry skid buffer.
module ram_burst_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  ram_burst_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic              busy_r;
  logic              done_r;
  logic              valid_r;
  logic              last_r;
  logic [DATA_W-1:0] data_r;

  logic load;
  logic accept;

  assign accept = valid_r & bus.m_ready;
  assign load   = (state == READ) && (remaining != '0) && (!valid_r || bus.m_ready);

  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = cur_addr;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.m_valid  = valid_r;
  assign bus.m_data   = data_r;
  assign bus.m_last   = last_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      data_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= READ;
            busy_r <= 1'b1;
            // len == 0 also passes through READ (remaining stays 0) so that
            // done lands two cycles after start, same as the L-byte formula.
            if (bus.len != '0) begin
              cur_addr  <= bus.start_addr;
              remaining <= bus.len;
            end
          end
        end
        READ: begin
          if (load) begin
            data_r    <= bus.ram_dout;
            valid_r   <= 1'b1;
            last_r    <= (remaining == REM_ONE);
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
          end else if (accept) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end
          if ((accept && last_r) || (remaining == '0 && !valid_r)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: table of bursts plus reset-mid-burst sequence,
// with a scoreboard of expected beats checked on every handshake.
module tb_ram_burst_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_burst_reader_if #(.ADDR_W(6), .DATA_W(8)) bus ();
  ram_burst_reader #(.ADDR_W(6), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // 64 x 8 RAM: write on the clock edge, combinational read
  logic [7:0] mem [64];
  logic       pre_we;
  logic [5:0] pre_addr;
  logic [7:0] pre_data;
  always @(posedge clk)
    if (pre_we || bus.ram_we) mem[pre_we ? pre_addr : bus.ram_addr] <= pre_data;
  assign bus.ram_dout = mem[bus.ram_addr];

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [5:0]  addr;
    logic [6:0]  len;
    logic [15:0] pat;
    int          restart_k;
    int          first_k;
    int          done_k;
  } vec_t;
  vec_t vecs[7];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    return 8'(a % 64) ^ 8'hA5;
  endfunction

  // Stream monitor: hold stability, last qualification, scoreboard compare
  logic       held = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      held = 1'b0;
    end else begin
      check("ram_we", int'(bus.ram_we), 0);
      if (held) begin
        check("hold_valid", int'(bus.m_valid), 1);
        check("hold_data", int'(bus.m_data), int'(held_data));
        check("hold_last", int'(bus.m_last), int'(held_last));
      end
      if (!bus.m_valid) check("last_without_valid", int'(bus.m_last), 0);
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", bus.m_data);
        end else begin
          b = sb.pop_front();
          check("beat_data", int'(bus.m_data), int'(b.data));
          check("beat_last", int'(bus.m_last), int'(b.last));
        end
      end
      held      = bus.m_valid && !bus.m_ready;
      held_data = bus.m_data;
      held_last = bus.m_last;
    end
  end

  task automatic run(input vec_t v);
    int k;
    int first_k;
    bit fin;
    for (int i = 0; i < int'(v.len); i++)
      sb.push_back('{data: exp_byte(int'(v.addr) + i), last: (i == int'(v.len) - 1)});
    bus.start      = 1'b1;
    bus.start_addr = v.addr;
    bus.len        = v.len;
    bus.m_ready    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    if (v.len != 0) check("ram_addr_after_start", int'(bus.ram_addr), int'(v.addr));
    k = 1;
    first_k = 0;
    fin = 1'b0;
    while (!fin && k <= 200) begin
      bus.m_ready = (k < 2 || k - 2 > 15) ? 1'b1 : v.pat[k-2];
      bus.start   = (k == v.restart_k);
      if (bus.start) begin
        bus.start_addr = 6'd5;
        bus.len        = 7'd2;
      end
      if (bus.m_valid && first_k == 0) first_k = k;
      if (bus.done) fin = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("done_cycle", fin ? k : -1, v.done_k);
    check("first_valid_cycle", first_k, v.first_k);
    bus.start   = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", int'(bus.done), 0);
    check("busy_after_done", int'(bus.busy), 0);
    check("valid_after_done", int'(bus.m_valid), 0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{6'd10, 7'd4,  16'hFFFF, 0, 2, 6};
    vecs[1] = '{6'd62, 7'd4,  16'hFFFF, 0, 2, 6};
    vecs[2] = '{6'd40, 7'd3,  16'hFFF9, 0, 2, 7};
    vecs[3] = '{6'd0,  7'd64, 16'hFFFF, 0, 2, 66};
    vecs[4] = '{6'd0,  7'd0,  16'hFFFF, 0, 0, 2};
    vecs[5] = '{6'd60, 7'd8,  16'hFFFF, 0, 2, 10};
    vecs[6] = '{6'd20, 7'd6,  16'hFFFF, 3, 2, 8};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.len = '0;
    bus.m_ready = 1'b1;
    pre_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pre_addr = 6'(i);
      pre_data = 8'(i) ^ 8'hA5;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_valid", int'(bus.m_valid), 0);
    check("rst_last", int'(bus.m_last), 0);
    check("rst_ram_we", int'(bus.ram_we), 0);
    check("rst_ram_addr", int'(bus.ram_addr), 0);
    check("rst_data", int'(bus.m_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Reset after two of eight beats: burst dropped, no done
    for (int i = 0; i < 8; i++)
      sb.push_back('{data: exp_byte(30 + i), last: (i == 7)});
    bus.start = 1'b1;
    bus.start_addr = 6'd30;
    bus.len = 7'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", int'(bus.m_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ram_addr", int'(bus.ram_addr), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_last", int'(bus.m_last), 0);
    check("beats_before_reset", 8 - sb.size(), 2);
    sb.delete();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", int'(bus.done), 0);
    end
    run(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
